// File: rtl/serial_sub.sv
// Bit-serial subtractor: x - y - b_in over WIDTH cycles through one difference/borrow stage.
// A start/busy/done handshake frames each operation; d and b_out hold until the next result.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic             r_br;
    logic [CW-1:0]    r_count;

    logic             w_accept;
    logic             w_lastStep;
    logic             w_diff;
    logic             w_borrow;

    assign w_diff     = r_a[0] ^ r_b[0] ^ r_br;
    assign w_borrow   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_lastStep = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // busy and done are pure decodes of the state register, so no input reaches them combinationally.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = RUN;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_br    <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_a     <= x;
            r_b     <= y;
            r_br    <= b_in;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_r     <= {w_diff, r_r[WIDTH-1:1]};
            r_br    <= w_borrow;
            r_count <= r_count + CW'(1);
        end
    end

    // The final bit step and the result load share one edge, so the result takes the stage outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d     <= '0;
            b_out <= 1'b0;
        end else if ((r_state == RUN) && w_lastStep) begin
            d     <= {w_diff, r_r[WIDTH-1:1]};
            b_out <= w_borrow;
        end
    end

endmodule
